// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte-wide memory bus responder: RAM, UART TX FIFO, RX holding register, halt
module mem_responder #(
    parameter int RAM_ADDR_W = 17,
    parameter int TX_DEPTH   = 8,
    parameter int IO_SEL_HI  = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        sim_halt
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(TX_DEPTH);
    localparam logic [CW-1:0] MARGIN_C = CW'(TX_DEPTH - 2);

    logic [7:0]            ram_q [2**RAM_ADDR_W];
    logic [7:0]            fifo_q [TX_DEPTH];
    logic [PW-1:0]         head_q, tail_q;
    logic [CW-1:0]         count_q, count_d;
    logic [7:0]            mem_din_q, mem_din_d;
    logic                  buf_full_q, halt_q;
    logic [7:0]            rx_data_q, rx_data_d;
    logic                  rx_full_q, rx_full_d;

    logic                  is_io, rd_ram, wr_ram, rd_io, wr_io;
    logic                  tx_full, push, pop, rx_pop;
    logic [2:0]            off;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic                  unused_addr;

    assign is_io   = (mem_a[IO_SEL_HI -: 2] == 2'b11);
    assign off     = mem_a[2:0];
    assign ram_idx = mem_a[RAM_ADDR_W-1:0];
    assign unused_addr = ^mem_a[31:IO_SEL_HI+1];

    assign rd_ram = rdy && !mem_wr && !is_io;
    assign wr_ram = rdy &&  mem_wr && !is_io;
    assign rd_io  = rdy && !mem_wr &&  is_io;
    assign wr_io  = rdy &&  mem_wr &&  is_io;

    // A pop frees the slot in the same edge, so a full FIFO still accepts a concurrent push.
    assign tx_full = (count_q == DEPTH_C);
    assign pop     = rdy && uart_tx_ready && (count_q != '0);
    assign push    = wr_io && (off == 3'd0) && (!tx_full || pop);
    assign count_d = count_q + CW'(push) - CW'(pop);
    assign rx_pop  = rd_io && (off == 3'd0);

    always_comb begin
        mem_din_d = mem_din_q;
        if (rd_ram) begin
            mem_din_d = ram_q[ram_idx];
        end else if (rd_io) begin
            case (off)
                3'd0:    mem_din_d = rx_full_q ? rx_data_q : 8'h00;
                3'd4:    mem_din_d = {6'b0, rx_full_q, tx_full};
                default: mem_din_d = 8'h00;
            endcase
        end
    end

    // A new byte wins over a same-edge pop; the pop still returns the old byte via mem_din_d.
    always_comb begin
        rx_data_d = rx_data_q;
        rx_full_d = rx_full_q;
        if (rdy && uart_rx_valid) begin
            rx_data_d = uart_rx_data;
            rx_full_d = 1'b1;
        end else if (rx_pop) begin
            rx_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_din_q  <= 8'h00;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            buf_full_q <= 1'b0;
            halt_q     <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_full_q  <= 1'b0;
            for (int i = 0; i < TX_DEPTH; i++) begin
                fifo_q[i] <= 8'h00;
            end
        end else begin
            mem_din_q  <= mem_din_d;
            count_q    <= count_d;
            buf_full_q <= (count_d >= MARGIN_C);
            rx_data_q  <= rx_data_d;
            rx_full_q  <= rx_full_d;
            if (push) begin
                fifo_q[tail_q] <= mem_dout;
                tail_q         <= tail_q + PW'(1);
            end
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
            if (wr_io && off == 3'd4) begin
                halt_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram_q[ram_idx] <= mem_dout;
        end
    end

    assign mem_din        = mem_din_q;
    assign io_buffer_full = buf_full_q;
    assign uart_tx_data   = fifo_q[head_q];
    assign uart_tx_valid  = (count_q != '0);
    assign sim_halt       = halt_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder against a queue-based reference model
module tb_mem_responder;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b0;
    logic [31:0] mem_a = '0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_dout = '0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic        uart_rx_valid = 1'b0;
    logic        sim_halt;

    mem_responder dut (
        .clk(clk), .rst(rst), .rdy(rdy), .mem_a(mem_a), .mem_wr(mem_wr),
        .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
        .uart_tx_ready(uart_tx_ready), .uart_rx_data(uart_rx_data),
        .uart_rx_valid(uart_rx_valid), .sim_halt(sim_halt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] ram_m [int];
    int         cnt_m = 0;
    logic       rxf_m = 1'b0;
    logic [7:0] rxb_m = '0;
    logic       halt_m = 1'b0;
    logic       bfull_m = 1'b0;
    int         exp_din[$];
    logic [7:0] exp_tx[$];
    logic       exp_valid = 1'b0, exp_bfull = 1'b0, exp_halt = 1'b0;
    logic       rd_pend = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) rd_pend <= 1'b0;
        else     rd_pend <= rdy && !mem_wr;
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("tx_valid", int'(uart_tx_valid), int'(exp_valid));
            chk("io_buffer_full", int'(io_buffer_full), int'(exp_bfull));
            chk("sim_halt", int'(sim_halt), int'(exp_halt));
            if (rd_pend) begin
                if (exp_din.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL mem_din_unexpected actual=%0h expected=none", mem_din);
                end else begin
                    chk("mem_din", int'(mem_din), exp_din.pop_front());
                end
            end
            if (uart_tx_valid && uart_tx_ready && rdy) begin
                if (exp_tx.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL tx_pop_unexpected actual=%0h expected=none", uart_tx_data);
                end else begin
                    chk("tx_data", int'(uart_tx_data), int'(exp_tx.pop_front()));
                end
            end
        end
    end

    task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d,
                       input logic txr, input logic rxv, input logic [7:0] rxd, input logic en);
        logic       io, pop_m, push_m;
        logic [2:0] off;
        int         idx, ev;
        mem_a = a; mem_wr = wr; mem_dout = d; uart_tx_ready = txr;
        uart_rx_valid = rxv; uart_rx_data = rxd; rdy = en;
        exp_valid = (cnt_m != 0); exp_bfull = bfull_m; exp_halt = halt_m;
        io = (a[17:16] == 2'b11); off = a[2:0]; idx = int'(a[16:0]);
        if (en) begin
            pop_m = txr && (cnt_m > 0);
            if (!wr) begin
                if (!io)            ev = ram_m.exists(idx) ? int'(ram_m[idx]) : 0;
                else if (off == 0)  ev = rxf_m ? int'(rxb_m) : 0;
                else if (off == 4)  ev = (rxf_m ? 2 : 0) + ((cnt_m == D) ? 1 : 0);
                else                ev = 0;
                exp_din.push_back(ev);
            end
            push_m = wr && io && (off == 0) && ((cnt_m < D) || pop_m);
            if (push_m) exp_tx.push_back(d);
            cnt_m = cnt_m + int'(push_m) - int'(pop_m);
            if (rxv) begin rxb_m = rxd; rxf_m = 1'b1; end
            else if (!wr && io && off == 0) rxf_m = 1'b0;
            if (wr && !io) ram_m[idx] = d;
            if (wr && io && off == 4) halt_m = 1'b1;
            bfull_m = (cnt_m >= D - 2);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic txr);
        cyc(32'h0003_0007, 1'b1, 8'h00, txr, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_din"}, int'(mem_din), 0);
        chk({tag, "_bfull"}, int'(io_buffer_full), 0);
        chk({tag, "_tx_valid"}, int'(uart_tx_valid), 0);
        chk({tag, "_tx_data"}, int'(uart_tx_data), 0);
        chk({tag, "_halt"}, int'(sim_halt), 0);
    endtask

    initial begin
        logic [31:0] word, r;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        // RAM write then read, and a streamed word
        cyc(32'h0000_0010, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc(32'h0000_0010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("ram_a5", int'(mem_din), 8'hA5);
        cyc(32'h0000_0100, 1'b1, 8'h13, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc(32'h0000_0101, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc(32'h0000_0102, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc(32'h0000_0103, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        word = '0;
        for (int i = 0; i < 4; i++) begin
            cyc(32'h0000_0100 + 32'(i), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
            word[8*i +: 8] = mem_din;
        end
        chk("word_reassembly", int'(word), 32'h0000_0513);

        // UART TX "Hi" with ready held high
        cyc(32'h0003_0000, 1'b1, 8'h48, 1'b1, 1'b0, 8'h00, 1'b1);
        cyc(32'h0003_0000, 1'b1, 8'h69, 1'b1, 1'b0, 8'h00, 1'b1);
        idle(1'b1);
        chk("hi_drained", int'(uart_tx_valid), 0);

        // Fill the FIFO with ready low, overflow by one, then drain
        for (int i = 1; i <= 9; i++) begin
            cyc(32'h0003_0000, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 8'h00, 1'b1);
            if (i == 5) chk("bfull_after5", int'(io_buffer_full), 0);
            if (i == 6) chk("bfull_after6", int'(io_buffer_full), 1);
        end
        cyc(32'h0003_0004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("status_full", int'(mem_din), 8'h01);
        for (int i = 0; i < 8; i++) idle(1'b1);
        chk("drain_empty", int'(uart_tx_valid), 0);

        // RX holding register
        cyc(32'h0003_0007, 1'b1, 8'h00, 1'b0, 1'b1, 8'h7A, 1'b1);
        cyc(32'h0003_0004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("status_rx", int'(mem_din), 8'h02);
        cyc(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("rx_byte", int'(mem_din), 8'h7A);
        cyc(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("rx_empty", int'(mem_din), 8'h00);

        // Randomized traffic over a private RAM window and the IO window
        for (int i = 0; i < 16; i++)
            cyc(32'h0000_0200 + 32'(i), 1'b1, 8'($urandom), 1'b0, 1'b0, 8'h00, 1'b1);
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            logic        wr;
            r = $urandom;
            case ($urandom % 10)
                0, 1:    begin a = {r[31:18], 18'h00200 + 18'(r[3:0])}; wr = 1'b0; end
                2:       begin a = {r[31:18], 18'h00200 + 18'(r[3:0])}; wr = 1'b1; end
                3, 4, 5: begin a = {r[31:18], 2'b11, r[15:3], 3'd0}; wr = 1'b1; end
                6:       begin a = {r[31:18], 2'b11, r[15:3], 3'd0}; wr = 1'b0; end
                7:       begin a = {r[31:18], 2'b11, r[15:3], 3'd4}; wr = 1'b0; end
                8:       begin a = {r[31:18], 2'b11, r[15:3], r[2:0]}; wr = r[16]; end
                default: begin a = {r[31:18], 2'b11, r[15:3], 3'd4}; wr = (r[7:0] == 8'h00); end
            endcase
            cyc(a, wr, 8'($urandom), 1'($urandom), ($urandom % 6) == 0, 8'($urandom),
                ($urandom % 8) != 0);
        end

        // Halt, then asynchronous reset mid-drain
        cyc(32'h0003_0004, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("halt_set", int'(sim_halt), 1);
        for (int i = 0; i < 8; i++) idle(1'b1);
        for (int i = 0; i < 4; i++)
            cyc(32'h0003_0000, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 8'h00, 1'b1);
        idle(1'b1);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("async_reset");
        cnt_m = 0; rxf_m = 1'b0; halt_m = 1'b0; bfull_m = 1'b0;
        exp_tx.delete(); exp_din.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(32'h0000_0010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("ram_kept", int'(mem_din), 8'hA5);
        cyc(32'h0003_0004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        idle(1'b0);

        @(negedge clk); #1;
        chk("scoreboard_drained", exp_din.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the byte-wide memory bus driven by the instruction/data cache.
- Decodes `mem_a`. Serves a synchronous byte RAM with 1-cycle read latency.
- Maps a small IO window: UART TX FIFO, UART RX holding register, status register and simulation halt.
- Generates `io_buffer_full` back to the cache.

Parameters:
- RAM_ADDR_W, 17, RAM size is 2^RAM_ADDR_W bytes; RAM index is mem_a[RAM_ADDR_W-1:0].
- TX_DEPTH, 8, UART TX FIFO entries; power of two, at least 4.
- IO_SEL_HI, 17, IO window selected when mem_a[IO_SEL_HI:IO_SEL_HI-1] == 2'b11 (0x30000–0x3FFFF at default).

Ports:
- clk, in, 1: system clock; all state updates on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- rdy, in, 1: global enable; when low, no state changes except reset.
- mem_a, in, 32: byte address from the cache.
- mem_wr, in, 1: 1 = write this cycle, 0 = read.
- mem_dout, in, 8: write data from the cache.
- mem_din, out, 8: registered read data to the cache.
- io_buffer_full, out, 1: TX FIFO nearly full; the cache must not issue IO writes.
- uart_tx_data, out, 8: head of the TX FIFO.
- uart_tx_valid, out, 1: TX FIFO non-empty.
- uart_tx_ready, in, 1: UART consumes the head this cycle when uart_tx_valid is also 1.
- uart_rx_data, in, 8: received byte.
- uart_rx_valid, in, 1: received byte valid, single-cycle pulse.
- sim_halt, out, 1: sticky halt flag.

Behaviour:
- Reset values: mem_din=0, io_buffer_full=0, uart_tx_valid=0, uart_tx_data=0, sim_halt=0; TX FIFO empty; RX register empty.
  - RAM contents are not reset.
  - Reset mid-transaction discards FIFO contents and any in-flight read.
- Decode: is_io = (mem_a[IO_SEL_HI:IO_SEL_HI-1] == 2'b11); otherwise RAM. Bits above IO_SEL_HI are ignored.
- RAM write: at an edge with rdy && mem_wr && !is_io, ram[mem_a[RAM_ADDR_W-1:0]] <= mem_dout.
- RAM read: at an edge with rdy && !mem_wr && !is_io, mem_din <= ram[index].
  - Data is visible the cycle after the address is presented (1-cycle latency). The cache relies on this when it streams consecutive byte addresses.
  - Read of an address written at the same edge returns the old byte (read-before-write). A write cycle does not update mem_din.
- IO read, offset = mem_a[2:0]. Any side effect happens on the same edge; data appears next cycle.
  - Offset 0: mem_din <= RX byte if full, else 0. The RX register is cleared (pop).
  - Offset 4: mem_din <= {6'b0, rx_full, tx_full}, where tx_full = (count == TX_DEPTH).
  - Other offsets: mem_din <= 0.
- IO write:
  - Offset 0: push mem_dout into the TX FIFO if count < TX_DEPTH; otherwise the byte is silently dropped.
  - Offset 4: sim_halt <= 1. Sticky until reset.
  - Other offsets: ignored.
- TX FIFO:
  - Circular buffer with head/tail pointers and a count of width clog2(TX_DEPTH)+1.
  - Pop when uart_tx_valid && uart_tx_ready && rdy.
  - uart_tx_data = mem[head]; uart_tx_valid = (count != 0).
  - Simultaneous push and pop on a full FIFO: pop first, push accepted, count unchanged.
  - Simultaneous push and pop on an empty FIFO: push only; no pop, since valid was 0.
  - Pointers wrap modulo TX_DEPTH.
- io_buffer_full:
  - Registered; next value = (next_count >= TX_DEPTH-2).
  - The 2-entry margin absorbs the cache's address-then-write pipeline: a write already in flight when the flag rises is still accepted.
- RX register:
  - On uart_rx_valid && rdy: load the byte and set rx_full. If already full, overwrite (newest wins).
  - Load coinciding with an offset-0 pop: the pop returns the old byte and the new byte is kept; rx_full stays 1.
- rdy low: no RAM writes, no FIFO or RX updates, no pops; mem_din holds its value.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 → mem_din == 0xA5 exactly one cycle after the read address.
- Stream reads of 0x100..0x103 holding 0x13,0x05,0x00,0x00 → mem_din sequence 0x13,0x05,0x00,0x00 on consecutive cycles; word reassembles to 0x00000513.
- Write 'H','i' to 0x30000 with uart_tx_ready=1 → uart_tx_data 0x48 then 0x69 on uart_tx_valid; FIFO empty after 2 pops.
- TX_DEPTH=8, uart_tx_ready=0: push 8 bytes → io_buffer_full=1 after the 6th push.
  - 9th push dropped; status read at 0x30004 returns 0x01.
  - Enable ready → exactly 8 bytes out, in order.
- uart_rx_valid pulse with 0x7A, then read 0x30004 → 0x02; read 0x30000 → 0x7A; second read 0x30000 → 0x00.
- Write to 0x30004 → sim_halt=1 next cycle; assert rst asynchronously mid-FIFO-drain → all outputs 0 immediately, RAM byte at 0x10 still 0xA5.
